// File: rtl/riscv_branch_unit_if.sv
// Execute/fetch-facing signal bundle of the branch unit; the unit itself takes
// the slave modport, the driving pipeline (or bench) takes the master modport.
interface riscv_branch_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  i_riscv_bu_fetch_pc;
  logic             o_riscv_bu_pred_taken;
  logic             i_riscv_bu_ex_valid;
  logic [3:0]       i_riscv_bu_cond;
  logic [XLEN-1:0]  i_riscv_bu_rs1data;
  logic [XLEN-1:0]  i_riscv_bu_rs2data;
  logic [XLEN-1:0]  i_riscv_bu_ex_pc;
  logic             i_riscv_bu_ex_pred;
  logic             i_riscv_bu_flush;
  logic             o_riscv_bu_valid;
  logic             o_riscv_bu_taken;
  logic             o_riscv_bu_mispredict;
  logic [CNT_W-1:0] o_riscv_bu_branch_cnt;
  logic [CNT_W-1:0] o_riscv_bu_mispred_cnt;

  modport master (
    output i_riscv_bu_fetch_pc, i_riscv_bu_ex_valid, i_riscv_bu_cond,
           i_riscv_bu_rs1data, i_riscv_bu_rs2data, i_riscv_bu_ex_pc,
           i_riscv_bu_ex_pred, i_riscv_bu_flush,
    input  o_riscv_bu_pred_taken, o_riscv_bu_valid, o_riscv_bu_taken,
           o_riscv_bu_mispredict, o_riscv_bu_branch_cnt, o_riscv_bu_mispred_cnt
  );

  modport slave (
    input  i_riscv_bu_fetch_pc, i_riscv_bu_ex_valid, i_riscv_bu_cond,
           i_riscv_bu_rs1data, i_riscv_bu_rs2data, i_riscv_bu_ex_pc,
           i_riscv_bu_ex_pred, i_riscv_bu_flush,
    output o_riscv_bu_pred_taken, o_riscv_bu_valid, o_riscv_bu_taken,
           o_riscv_bu_mispredict, o_riscv_bu_branch_cnt, o_riscv_bu_mispred_cnt
  );
endinterface

// File: rtl/riscv_branch_unit.sv
// Execute-stage branch resolver with a PC-indexed 2-bit-counter PHT feeding
// fetch predictions, registered resolution/mispredict and saturating perf counters.
module riscv_branch_unit #(
  parameter int XLEN      = 64,
  parameter int PHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic                i_riscv_bu_clk,
  input  logic                i_riscv_bu_rst,
  riscv_branch_unit_if.slave  bu
);
  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]       pht_r [PHT_DEPTH];
  logic             valid_r;
  logic             taken_r;
  logic             mispredict_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispred_cnt_r;

  logic [IDX_W-1:0] fetch_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             accept_s;
  logic             taken_s;
  logic             mispred_s;
  logic             train_s;
  logic [1:0]       pht_next_s;
  logic             unused_pc_bits_s;

  function automatic logic resolve_taken(input logic [3:0] cond,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    logic res;
    if (cond[3]) begin
      res = 1'b1;
    end else begin
      case (cond[2:0])
        3'b000:  res = (a == b);
        3'b001:  res = (a != b);
        3'b100:  res = ($signed(a) <  $signed(b));
        3'b101:  res = ($signed(a) >= $signed(b));
        3'b110:  res = (a <  b);
        3'b111:  res = (a >= b);
        default: res = 1'b0;
      endcase
    end
    return res;
  endfunction

  function automatic logic [1:0] counter_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign fetch_idx_s = bu.i_riscv_bu_fetch_pc[IDX_W+1:2];
  assign ex_idx_s    = bu.i_riscv_bu_ex_pc[IDX_W+1:2];
  // PC bits outside the index field intentionally do not participate.
  assign unused_pc_bits_s = &{1'b0, bu.i_riscv_bu_fetch_pc[1:0], bu.i_riscv_bu_ex_pc[1:0],
                              bu.i_riscv_bu_fetch_pc[XLEN-1:IDX_W+2],
                              bu.i_riscv_bu_ex_pc[XLEN-1:IDX_W+2]};

  // Resolve the execute-stage branch and work out the PHT training value.
  always_comb begin
    accept_s   = 1'b0;
    taken_s    = 1'b0;
    mispred_s  = 1'b0;
    train_s    = 1'b0;
    pht_next_s = pht_r[ex_idx_s];
    if (bu.i_riscv_bu_ex_valid && !bu.i_riscv_bu_flush) begin
      accept_s   = 1'b1;
      taken_s    = resolve_taken(bu.i_riscv_bu_cond, bu.i_riscv_bu_rs1data,
                                 bu.i_riscv_bu_rs2data);
      mispred_s  = taken_s ^ bu.i_riscv_bu_ex_pred;
      train_s    = !bu.i_riscv_bu_cond[3];
      pht_next_s = counter_step(pht_r[ex_idx_s], taken_s);
    end else begin
      accept_s = 1'b0;
    end
  end

  // Result registers, PHT training and performance counters.
  always_ff @(posedge i_riscv_bu_clk) begin
    if (i_riscv_bu_rst) begin
      valid_r       <= 1'b0;
      taken_r       <= 1'b0;
      mispredict_r  <= 1'b0;
      branch_cnt_r  <= '0;
      mispred_cnt_r <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_r[i] <= 2'b01;
      end
    end else begin
      valid_r      <= accept_s;
      taken_r      <= taken_s;
      mispredict_r <= mispred_s;
      if (train_s) begin
        pht_r[ex_idx_s] <= pht_next_s;
        branch_cnt_r    <= sat_inc(branch_cnt_r);
      end
      if (mispred_s) begin
        mispred_cnt_r <= sat_inc(mispred_cnt_r);
      end
    end
  end

  // No bypass: fetch sees the pre-update counter during a same-index write.
  assign bu.o_riscv_bu_pred_taken  = pht_r[fetch_idx_s][1];
  assign bu.o_riscv_bu_valid       = valid_r;
  assign bu.o_riscv_bu_taken       = taken_r;
  assign bu.o_riscv_bu_mispredict  = mispredict_r;
  assign bu.o_riscv_bu_branch_cnt  = branch_cnt_r;
  assign bu.o_riscv_bu_mispred_cnt = mispred_cnt_r;
endmodule

// File: tb/tb_riscv_branch_unit.sv
// Self-checking bench for riscv_branch_unit: directed scenarios plus a randomized
// run checked against an array-based reference model of the PHT and counters.
module tb_riscv_branch_unit;
  localparam int XLEN  = 64;
  localparam int DEPTH = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  int   m_pht [DEPTH];
  int   m_bcnt;
  int   m_mcnt;
  bit   m_valid;
  bit   m_taken;
  bit   m_mis;

  riscv_branch_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bu_if ();

  riscv_branch_unit #(.XLEN(XLEN), .PHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_riscv_bu_clk (clk),
    .i_riscv_bu_rst (rst),
    .bu             (bu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_taken(input logic [3:0] c, input logic [63:0] a,
                                   input logic [63:0] b);
    longint          sa = a;
    longint          sb = b;
    longint unsigned ua = a;
    longint unsigned ub = b;
    if (c[3]) return 1'b1;
    case (c[2:0])
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc_idx(input logic [63:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit m_pred(input logic [63:0] pc);
    return m_pht[pc_idx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_bcnt = 0; m_mcnt = 0; m_valid = 0; m_taken = 0; m_mis = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit acc;
    bit t;
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    acc = bu_if.i_riscv_bu_ex_valid && !bu_if.i_riscv_bu_flush;
    t   = acc && ref_taken(bu_if.i_riscv_bu_cond, bu_if.i_riscv_bu_rs1data,
                           bu_if.i_riscv_bu_rs2data);
    m_valid = acc;
    m_taken = t;
    m_mis   = acc && (t != bu_if.i_riscv_bu_ex_pred);
    if (acc && !bu_if.i_riscv_bu_cond[3]) begin
      k = pc_idx(bu_if.i_riscv_bu_ex_pc);
      m_pht[k] = t ? ((m_pht[k] < 3) ? m_pht[k] + 1 : 3) : ((m_pht[k] > 0) ? m_pht[k] - 1 : 0);
      m_bcnt   = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
    end
    if (m_mis) m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] epc, input bit pred,
                       input bit fl, input logic [63:0] fpc);
    bu_if.i_riscv_bu_ex_valid = v;
    bu_if.i_riscv_bu_cond     = c;
    bu_if.i_riscv_bu_rs1data  = a;
    bu_if.i_riscv_bu_rs2data  = b;
    bu_if.i_riscv_bu_ex_pc    = epc;
    bu_if.i_riscv_bu_ex_pred  = pred;
    bu_if.i_riscv_bu_flush    = fl;
    bu_if.i_riscv_bu_fetch_pc = fpc;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h100);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bu_if.o_riscv_bu_valid, bu_if.o_riscv_bu_taken, bu_if.o_riscv_bu_mispredict} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {bu_if.o_riscv_bu_valid,
               bu_if.o_riscv_bu_taken, bu_if.o_riscv_bu_mispredict});
    end
    checks++;
    if (bu_if.o_riscv_bu_branch_cnt !== 4'h0 || bu_if.o_riscv_bu_mispred_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%h/%h want=0/0", bu_if.o_riscv_bu_branch_cnt,
               bu_if.o_riscv_bu_mispred_cnt);
    end
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred got=%b want=0", bu_if.o_riscv_bu_pred_taken);
    end
  endtask

  task automatic test_funct3();
    logic [3:0] conds [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0010, 4'b1000};
    bit         want  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, conds[i], 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h400, 1'b0, 1'b0, 64'h0);
      tick();
      checks++;
      if (bu_if.o_riscv_bu_valid !== 1'b1 || bu_if.o_riscv_bu_taken !== want[i]) begin
        errors++;
        $display("FAIL funct3 cond=%b got v=%b t=%b want v=1 t=%b", conds[i],
                 bu_if.o_riscv_bu_valid, bu_if.o_riscv_bu_taken, want[i]);
      end
    end
  endtask

  task automatic test_pht_train();
    do_reset();
    drive(1'b1, 4'b0000, 64'd5, 64'd5, 64'h100, 1'b0, 1'b0, 64'h100);
    #1;
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL pht_initial got=%b want=0", bu_if.o_riscv_bu_pred_taken);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bu_if.o_riscv_bu_pred_taken !== 1'b1) begin
        errors++;
        $display("FAIL pht_train step=%0d got=%b want=1", i, bu_if.o_riscv_bu_pred_taken);
      end
    end
    // Saturated at 11: one not-taken must still predict taken (11 -> 10).
    drive(1'b1, 4'b0001, 64'd5, 64'd5, 64'h100, 1'b1, 1'b0, 64'h100);
    tick();
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL pht_saturate got=%b want=1", bu_if.o_riscv_bu_pred_taken);
    end
  endtask

  task automatic test_rdw();
    do_reset();
    drive(1'b1, 4'b0000, 64'd9, 64'd9, 64'h100, 1'b0, 1'b0, 64'h100);
    #1;
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rdw_same_cycle got=%b want=0", bu_if.o_riscv_bu_pred_taken);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b1 || bu_if.o_riscv_bu_mispredict !== 1'b1) begin
      errors++;
      $display("FAIL rdw_next got pred=%b mis=%b want 1/1", bu_if.o_riscv_bu_pred_taken,
               bu_if.o_riscv_bu_mispredict);
    end
    checks++;
    if (bu_if.o_riscv_bu_mispred_cnt !== 4'd1 || bu_if.o_riscv_bu_branch_cnt !== 4'd1) begin
      errors++;
      $display("FAIL rdw_cnt got=%0d/%0d want=1/1", bu_if.o_riscv_bu_mispred_cnt,
               bu_if.o_riscv_bu_branch_cnt);
    end
  endtask

  task automatic test_flush_jal();
    do_reset();
    drive(1'b1, 4'b0000, 64'd3, 64'd3, 64'h100, 1'b0, 1'b1, 64'h100);
    tick();
    checks++;
    if (bu_if.o_riscv_bu_valid !== 1'b0 || bu_if.o_riscv_bu_branch_cnt !== 4'd0 ||
        bu_if.o_riscv_bu_mispred_cnt !== 4'd0) begin
      errors++;
      $display("FAIL flush got v=%b b=%0d m=%0d want 0/0/0", bu_if.o_riscv_bu_valid,
               bu_if.o_riscv_bu_branch_cnt, bu_if.o_riscv_bu_mispred_cnt);
    end
    drive(1'b1, 4'b1000, 64'd1, 64'd2, 64'h100, 1'b0, 1'b0, 64'h100);
    tick();
    idle();
    #1;
    checks++;
    if (bu_if.o_riscv_bu_mispredict !== 1'b1 || bu_if.o_riscv_bu_mispred_cnt !== 4'd1 ||
        bu_if.o_riscv_bu_branch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL jal got mis=%b m=%0d b=%0d want 1/1/0", bu_if.o_riscv_bu_mispredict,
               bu_if.o_riscv_bu_mispred_cnt, bu_if.o_riscv_bu_branch_cnt);
    end
    checks++;
    if (bu_if.o_riscv_bu_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL jal_pht got=%b want=0", bu_if.o_riscv_bu_pred_taken);
    end
  endtask

  task automatic test_back_to_back();
    int lost;
    lost = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b0000, 64'd7, 64'd7, 64'(i * 4), 1'b0, 1'b0, 64'h0);
      tick();
      if (bu_if.o_riscv_bu_valid !== 1'b1) lost++;
    end
    checks++;
    if (lost != 0) begin
      errors++;
      $display("FAIL b2b_valid got=%0d gaps want=0", lost);
    end
    checks++;
    if (bu_if.o_riscv_bu_branch_cnt !== 4'hF || bu_if.o_riscv_bu_mispred_cnt !== 4'hF) begin
      errors++;
      $display("FAIL cnt_saturate got=%h/%h want=F/F", bu_if.o_riscv_bu_branch_cnt,
               bu_if.o_riscv_bu_mispred_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 4'b0000, 64'd1, 64'd1, 64'h200, 1'b1, 1'b0, 64'h200);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bu_if.i_riscv_bu_fetch_pc = 64'h200;
    #1;
    checks++;
    if (bu_if.o_riscv_bu_valid !== 1'b0 || bu_if.o_riscv_bu_branch_cnt !== 4'd0 ||
        bu_if.o_riscv_bu_mispred_cnt !== 4'd0 || bu_if.o_riscv_bu_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got v=%b b=%0d m=%0d p=%b want 0/0/0/0", bu_if.o_riscv_bu_valid,
               bu_if.o_riscv_bu_branch_cnt, bu_if.o_riscv_bu_mispred_cnt,
               bu_if.o_riscv_bu_pred_taken);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] epc;
    logic [63:0] fpc;
    int bad;
    bad = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {$urandom, $urandom};
        2: b = {~a[63], a[62:0]};
        default: begin a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3)); end
      endcase
      c   = ($urandom_range(0, 7) == 0) ? 4'b1000 : 4'($urandom_range(0, 7));
      epc = {$urandom, $urandom_range(0, 7), 2'($urandom)} ;
      fpc = ($urandom_range(0, 1) == 1) ? epc : {$urandom, $urandom};
      drive($urandom_range(0, 9) < 8, c, a, b, epc, 1'($urandom), $urandom_range(0, 9) == 0, fpc);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (bu_if.o_riscv_bu_pred_taken !== m_pred(fpc)) begin
        errors++;
        $display("FAIL rand_pred n=%0d got=%b want=%b", n, bu_if.o_riscv_bu_pred_taken, m_pred(fpc));
      end
      tick();
      checks++;
      if (bu_if.o_riscv_bu_valid !== m_valid || bu_if.o_riscv_bu_taken !== m_taken ||
          bu_if.o_riscv_bu_mispredict !== m_mis ||
          bu_if.o_riscv_bu_branch_cnt !== 4'(m_bcnt) || bu_if.o_riscv_bu_mispred_cnt !== 4'(m_mcnt)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_res n=%0d got v%b t%b m%b b%0d c%0d want v%b t%b m%b b%0d c%0d", n,
                   bu_if.o_riscv_bu_valid, bu_if.o_riscv_bu_taken, bu_if.o_riscv_bu_mispredict,
                   bu_if.o_riscv_bu_branch_cnt, bu_if.o_riscv_bu_mispred_cnt,
                   m_valid, m_taken, m_mis, m_bcnt, m_mcnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    model_reset();
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_funct3();
    test_pht_train();
    test_rdw();
    test_flush_jal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
